// File: rtl/booth_multiplier_if.sv
// Start/ready/write handshake bundle shared by the muldiv units.
// MULT_HI_OUT_EN adds the result_hi upper-product output.
interface booth_multiplier_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ctrl_MULT;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic             ready;
  logic             write;
  logic             busy;
`ifdef MULT_HI_OUT_EN
  logic [WIDTH-1:0] result_hi;
`endif

  modport master (
    output ctrl_MULT, A, B,
    input  result, exception, ready, write, busy
`ifdef MULT_HI_OUT_EN
    , input result_hi
`endif
  );

  modport slave (
    input  ctrl_MULT, A, B,
    output result, exception, ready, write, busy
`ifdef MULT_HI_OUT_EN
    , output result_hi
`endif
  );
endinterface

// File: rtl/booth_multiplier.sv
// Iterative radix-4 Booth signed multiplier, WIDTH/2 steps per operation.
// MULT_HI_OUT_EN exposes the upper product half on result_hi.
module booth_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  booth_multiplier_if.slave  bus
);

  localparam int unsigned AW    = WIDTH + 2;
  localparam int unsigned PW    = 2 * WIDTH + 3;
  localparam int unsigned STEPS = WIDTH / 2;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, WB} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    p_q;
  logic [AW-1:0]    m_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             exception_q;
  logic             ready_q, write_q, busy_q;

  logic [AW-1:0]      acc, sel, acc_sum;
  logic [PW-1:0]      p_step;
  logic [2*WIDTH-1:0] product;
  logic               last_step;

  // One Booth step: decode guard triplet, accumulate, arithmetic shift by 2
  always_comb begin
    acc = p_q[PW-1:WIDTH+1];
    sel = '0;
    case (p_q[2:0])
      3'b001, 3'b010: sel = m_q;
      3'b011:         sel = {m_q[AW-2:0], 1'b0};
      3'b100:         sel = -{m_q[AW-2:0], 1'b0};
      3'b101, 3'b110: sel = -m_q;
      default:        sel = '0;
    endcase
    acc_sum   = acc + sel;
    p_step    = {{2{acc_sum[AW-1]}}, acc_sum, p_q[WIDTH:2]};
    product   = p_step[2*WIDTH:1];
    last_step = (cnt_q == CW'(STEPS - 1));
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; a start pulse preempts whatever is in flight
  always_comb begin
    state_d = state_q;
    if (bus.ctrl_MULT) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     state_d = last_step ? DONE : RUN;
        DONE:    state_d = WB;
        WB:      state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and registered results
  always_ff @(posedge clock) begin
    if (reset) begin
      p_q         <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      exception_q <= 1'b0;
    end else if (bus.ctrl_MULT) begin
      p_q   <= {{AW{1'b0}}, bus.B, 1'b0};
      m_q   <= {{2{bus.A[WIDTH-1]}}, bus.A};
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      p_q   <= p_step;
      cnt_q <= cnt_q + CW'(1);
      if (last_step) begin
        result_q    <= product[WIDTH-1:0];
        exception_q <= (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}});
      end
    end
  end

  // Handshake strobes registered from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= (state_d == DONE);
      write_q <= (state_d == WB);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.result    = result_q;
  assign bus.exception = exception_q;
  assign bus.ready     = ready_q;
  assign bus.write     = write_q;
  assign bus.busy      = busy_q;

`ifdef MULT_HI_OUT_EN
  logic [WIDTH-1:0] result_hi_q;

  always_ff @(posedge clock) begin
    if (reset)                                       result_hi_q <= '0;
    else if (!bus.ctrl_MULT && state_q == RUN && last_step) result_hi_q <= product[2*WIDTH-1:WIDTH];
  end

  assign bus.result_hi = result_hi_q;
`endif

endmodule
